// File: rtl/muldiv_if.sv
// Request/response bundle between the execute-stage control
// and the iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WORDSIZE = 32,
    parameter int OPSIZE   = 3
);
    logic                START;
    logic [OPSIZE-1:0]   OP;
    logic [WORDSIZE-1:0] A;
    logic [WORDSIZE-1:0] B;
    logic                READY;
    logic                DONE;
    logic [WORDSIZE-1:0] R;
    logic                Z;
    logic                N;

    modport master (
        output START, OP, A, B,
        input  READY, DONE, R, Z, N
    );

    modport slave (
        input  START, OP, A, B,
        output READY, DONE, R, Z, N
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one operand bit per clock.
// Works on magnitudes; the result sign is applied after the last step.
module muldiv_unit #(
    parameter int WORDSIZE = 32,
    parameter int OPSIZE   = 3
) (
    input logic     CLK,
    input logic     RST,
    muldiv_if.slave io
);
    localparam int W  = WORDSIZE;
    localparam int CW = $clog2(WORDSIZE + 1);

    localparam logic [OPSIZE-1:0] OP_MUL    = 3'd0;
    localparam logic [OPSIZE-1:0] OP_MULH   = 3'd1;
    localparam logic [OPSIZE-1:0] OP_MULHSU = 3'd2;
    localparam logic [OPSIZE-1:0] OP_DIV    = 3'd4;
    localparam logic [OPSIZE-1:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OPSIZE-1:0] op_q, op_d;
    logic              neg_q, neg_d;
    logic [W-1:0]      mcand_q, mcand_d;
    logic [2*W-1:0]    acc_q, acc_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [W-1:0]      r_q, r_d;
    logic              z_q, z_d;
    logic              n_q, n_d;

    logic              a_sgn, b_sgn, sa, sb;
    logic [W-1:0]      mag_a, mag_b;
    logic              b_zero, ovf;
    logic [W-1:0]      spec_val;

    // Decode operand signedness and the single-cycle division cases
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (io.OP)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            OP_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
        sa       = a_sgn & io.A[W-1];
        sb       = b_sgn & io.B[W-1];
        mag_a    = sa ? -io.A : io.A;
        mag_b    = sb ? -io.B : io.B;
        b_zero   = io.OP[2] & (io.B == '0);
        ovf      = io.OP[2] & ~io.OP[0] & (&io.B)
                 & (io.A == {1'b1, {(W-1){1'b0}}});
        spec_val = io.OP[1] ? io.A : '1;
        if (!b_zero && ovf) begin
            spec_val = io.OP[1] ? '0 : io.A;
        end
    end

    logic [W:0]     mul_sum;
    logic [W:0]     rem_sh;
    logic [W:0]     diff;
    logic [2*W-1:0] iter_nxt;
    logic [2*W-1:0] prod;
    logic [W-1:0]   dval;
    logic [W-1:0]   fin_val;

    // One shift-add or restoring shift-subtract step, plus sign fix-up
    always_comb begin
        mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q};
        rem_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
        diff    = rem_sh - {1'b0, mcand_q};
        if (op_q[2]) begin
            if (!diff[W]) begin
                iter_nxt = {diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                iter_nxt = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            iter_nxt = {mul_sum, acc_q[W-1:1]};
        end else begin
            iter_nxt = {1'b0, acc_q[2*W-1:1]};
        end
        prod = neg_q ? -iter_nxt : iter_nxt;
        dval = op_q[1] ? iter_nxt[2*W-1:W] : iter_nxt[W-1:0];
        if (op_q[2]) begin
            fin_val = neg_q ? -dval : dval;
        end else if (op_q[1:0] == 2'd0) begin
            fin_val = prod[W-1:0];
        end else begin
            fin_val = prod[2*W-1:W];
        end
    end

    // Next-state and datapath control for IDLE/CALC/FIN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (io.START) begin
                    op_d = io.OP;
                    if (b_zero || ovf) begin
                        state_d = FIN;
                        r_d     = spec_val;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CW'(W);
                        neg_d   = (io.OP[2] & io.OP[1]) ? sa : (sa ^ sb);
                        mcand_d = io.OP[2] ? mag_b : mag_a;
                        acc_d   = {{W{1'b0}}, io.OP[2] ? mag_a : mag_b};
                    end
                end
            end
            CALC: begin
                acc_d = iter_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = FIN;
                    r_d     = fin_val;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        z_d     = (r_d == '0);
        n_d     = r_d[W-1];
        ready_d = (state_d == IDLE);
        done_d  = (state_d == FIN);
    end

    // State, datapath and registered outputs; reset wins over everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            r_q     <= '0;
            z_q     <= 1'b1;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            r_q     <= r_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign io.READY = ready_q;
    assign io.DONE  = done_q;
    assign io.R     = r_q;
    assign io.Z     = z_q;
    assign io.N     = n_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: 32-bit and 8-bit instances.
// Latency is counted in cycles after the accepting edge.
module tb_muldiv_unit;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    muldiv_if #(.WORDSIZE(32), .OPSIZE(3)) b32 ();
    muldiv_if #(.WORDSIZE(8), .OPSIZE(3))  b8 ();

    muldiv_unit #(.WORDSIZE(32), .OPSIZE(3)) u32 (
        .CLK(CLK), .RST(RST), .io(b32)
    );
    muldiv_unit #(.WORDSIZE(8), .OPSIZE(3)) u8 (
        .CLK(CLK), .RST(RST), .io(b8)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic run32(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r,
                         output logic z, output logic n,
                         output int lat, output logic busy_ok);
        @(posedge CLK); #1;
        b32.START = 1'b1;
        b32.OP    = op;
        b32.A     = a;
        b32.B     = b;
        @(posedge CLK); #1;
        b32.START = 1'b0;
        b32.A     = $urandom;
        b32.B     = $urandom;
        lat = -1; busy_ok = 1'b1; r = '0; z = 1'b0; n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (b32.READY) busy_ok = 1'b0;
            if (b32.DONE) begin
                lat = k; r = b32.R; z = b32.Z; n = b32.N;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge CLK);
            if (!b32.READY || b32.DONE) busy_ok = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        z, n, ok;
        int          lat;
        int          dcnt;
        int          dcyc [2];
        logic [7:0]  dr [2];
        logic        dn0, rdy0, rdy10;

        vt[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        vt[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
        vt[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vt[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vt[4]  = '{3'd0, 32'd0,        32'h123,      32'd0,        33};
        vt[5]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vt[6]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vt[7]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
        vt[8]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
        vt[9]  = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vt[10] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
        vt[11] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vt[12] = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
        vt[13] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vt[14] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vt[15] = '{3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};
        vt[16] = '{3'd7, 32'hFFFFFFFF, 32'd10,       32'd5,        33};
        vt[17] = '{3'd3, 32'h00010000, 32'h00010000, 32'd1,        33};

        b32.START = 1'b0; b32.OP = '0; b32.A = '0; b32.B = '0;
        b8.START  = 1'b0; b8.OP  = '0; b8.A  = '0; b8.B  = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst32_ready", 64'(b32.READY), 64'(1));
        chk("rst32_done",  64'(b32.DONE),  64'(0));
        chk("rst32_r",     64'(b32.R),     64'(0));
        chk("rst32_zn",    64'({b32.Z, b32.N}), 64'(2'b10));
        chk("rst8_ready",  64'(b8.READY),  64'(1));
        chk("rst8_rzn",    64'({b8.R, b8.Z, b8.N}), 64'({8'h00, 2'b10}));

        for (int i = 0; i < NV; i++) begin
            run32(vt[i].op, vt[i].a, vt[i].b, r, z, n, lat, ok);
            chk($sformatf("v%0d_r", i), 64'(r), 64'(vt[i].r));
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
            chk($sformatf("v%0d_zn", i), 64'({z, n}),
                64'({vt[i].r == 32'd0, vt[i].r[31]}));
            chk($sformatf("v%0d_hs", i), 64'(ok), 64'(1));
        end

        // Reset during CALC cycle 10: no DONE may follow
        @(posedge CLK); #1;
        b32.START = 1'b1; b32.OP = 3'd5; b32.A = 32'd100; b32.B = 32'd7;
        @(posedge CLK); #1;
        b32.START = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_ready", 64'(b32.READY), 64'(1));
        chk("midrst_done",  64'(b32.DONE),  64'(0));
        chk("midrst_rz",    64'({b32.R, b32.Z}), 64'({32'd0, 1'b1}));
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (b32.DONE) dcnt++;
        end
        chk("midrst_nodone", 64'(dcnt), 64'(0));

        // START while busy is ignored
        @(posedge CLK); #1;
        b32.START = 1'b1; b32.OP = 3'd0; b32.A = 32'd6; b32.B = 32'd7;
        @(posedge CLK); #1;
        b32.START = 1'b0;
        lat = -1; r = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 5) begin
                b32.START = 1'b1; b32.OP = 3'd5;
                b32.A = 32'd100; b32.B = 32'd7;
            end
            if (k == 6) b32.START = 1'b0;
            if (b32.DONE) begin
                lat = k; r = b32.R;
                break;
            end
        end
        chk("busy_r",   64'(r),   64'(42));
        chk("busy_lat", 64'(lat), 64'(33));
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (b32.DONE) dcnt++;
        end
        chk("busy_noqueue", 64'(dcnt), 64'(0));

        // 8-bit instance with START held high across two accepts
        @(posedge CLK); #1;
        b8.START = 1'b1; b8.OP = 3'd0; b8.A = 8'h0F; b8.B = 8'h11;
        dcnt = 0; dcyc[0] = -1; dcyc[1] = -1;
        dr[0] = '0; dr[1] = '0; dn0 = 1'b0; rdy0 = 1'b0; rdy10 = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            @(negedge CLK);
            if (k == 0)  rdy0  = b8.READY;
            if (k == 10) rdy10 = b8.READY;
            if (b8.DONE) begin
                if (dcnt < 2) begin
                    dcyc[dcnt] = k;
                    dr[dcnt]   = b8.R;
                    if (dcnt == 0) dn0 = b8.N;
                end
                dcnt++;
            end
            @(posedge CLK); #1;
            if (k == 0) begin
                b8.OP = 3'd3; b8.A = 8'hFF; b8.B = 8'hFF;
            end
            if (k == 10) b8.START = 1'b0;
        end
        chk("w8_rdy0",   64'(rdy0),    64'(1));
        chk("w8_rdy10",  64'(rdy10),   64'(1));
        chk("w8_ndone",  64'(dcnt),    64'(2));
        chk("w8_done0",  64'(dcyc[0]), 64'(9));
        chk("w8_done1",  64'(dcyc[1]), 64'(19));
        chk("w8_mul",    64'(dr[0]),   64'(8'hFF));
        chk("w8_mul_n",  64'(dn0),     64'(1));
        chk("w8_mulhu",  64'(dr[1]),   64'(8'hFE));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
